arith_md: RTL
=============

ARITH_MD -- requirements
Module: arith_md

Interface
REQ-001 Parameter XLEN, default 32, operand/result width; SHALL support 8 to 64.
REQ-002 rst_n_i  input  1  async active-low reset; SHALL be named rst_n_i.
REQ-003 clk_i  input  1  single rising-edge clock; SHALL be named clk_i.
REQ-004 req_valid_i  input  1  request present.
REQ-005 req_ready_o  output  1  unit can accept a request.
REQ-006 funct_i  input  3  op: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-007 op1_i  input  XLEN  multiplicand/dividend (rs1).
REQ-008 op2_i  input  XLEN  multiplier/divisor (rs2).
REQ-009 flush_i  input  1  abort in-flight op, drop response.
REQ-010 resp_valid_o  output  1  result present.
REQ-011 resp_ready_i  input  1  consumer accepts result.
REQ-012 res_o  output  XLEN  result.

Function
REQ-013 FSM states IDLE, BUSY, DONE; SHALL accept a request only when req_valid_i && req_ready_o (acceptance cycle T).
REQ-014 req_ready_o SHALL be 1 only in IDLE; funct_i/op1_i/op2_i SHALL be registered at T and ignored afterwards.
REQ-015 IDLE->BUSY on acceptance; BUSY lasts exactly XLEN cycles (one bit per cycle, shift-add multiply, restoring divide); BUSY->DONE after iteration XLEN; resp_valid_o SHALL first be 1 in cycle T+XLEN+1.
REQ-016 DONE->IDLE when resp_ready_i=1; res_o and resp_valid_o SHALL hold stable while resp_valid_o && !resp_ready_i.
REQ-017 MUL SHALL return low XLEN bits of the product; MULH signed x signed, MULHSU signed op1 x unsigned op2, MULHU unsigned x unsigned SHALL return high XLEN bits of the 2*XLEN product.
REQ-018 Signed divide SHALL operate on magnitudes, then negate quotient if operand signs differ and remainder if dividend negative (quotient truncates toward zero).
REQ-019 Divide by zero: quotient SHALL be all ones, remainder SHALL be op1; SHALL bypass BUSY, resp_valid_o at T+1.
REQ-020 Signed overflow (DIV/REM, op1=-2^(XLEN-1), op2=-1): quotient SHALL be op1, remainder 0; SHALL bypass BUSY, resp_valid_o at T+1.
REQ-021 flush_i=1 in any state SHALL force IDLE next cycle with resp_valid_o=0; flush_i has priority over acceptance in the same cycle.
REQ-022 res_o SHALL be 0 whenever resp_valid_o=0.

Reset
REQ-023 rst_n_i low SHALL asynchronously force IDLE, req_ready_o=1 after release, resp_valid_o=0, res_o=0, iteration counter and datapath registers 0.
REQ-024 Reset mid-operation SHALL discard the operation; no response SHALL appear after release.

Configuration
REQ-025 Macro ARITH_MD_FAST_MUL_EN: defined -> MUL/MULH/MULHSU/MULHU SHALL compute with a single-cycle multiplier, bypass BUSY, resp_valid_o at T+1; divide timing unchanged.
REQ-026 Undefined -> all multiply ops SHALL use the iterative XLEN-cycle path of REQ-015.

Verification (XLEN=32, macro undefined unless stated)
REQ-027 MUL 7 x -3 accepted at T -> resp_valid_o at T+33, res_o=0xFFFFFFEB; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
REQ-028 DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2, each at T+33.
REQ-029 DIVU 5/0 -> 0xFFFFFFFF at T+1; REM 5/0 -> 5; DIV 0x80000000/-1 -> 0x80000000 at T+1, REM -> 0.
REQ-030 resp_ready_i held 0 for 5 cycles after result -> res_o/resp_valid_o stable, req_ready_o=0; resp_ready_i=1 -> IDLE next cycle, next request accepted.
REQ-031 flush_i at T+10 of a DIV -> resp_valid_o never asserts, req_ready_o=1 at T+11; rst_n_i low at T+5 of a MUL -> outputs 0 immediately, no response after release.
REQ-032 ARITH_MD_FAST_MUL_EN defined: MULH 0x80000000 x 0x80000000 -> 0x40000000 at T+1; DIVU 100/7 still at T+33.

Source files
------------

// File: rtl/arith_md.sv
// arith_md -- iterative multiply/divide unit (RISC-V M-extension semantics).
//
// One operation in flight at a time. The operation is accepted when
// req_valid_i && req_ready_o. Multiplies use a shift-add loop and divides use
// a restoring loop. Each loop retires one bit per cycle for XLEN cycles.
// Divide-by-zero and signed overflow results are resolved at acceptance, so
// they skip the loop and respond one cycle after acceptance.
//
// Optional feature macro: ARITH_MD_FAST_MUL_EN
//   defined   -> all multiply ops use a single-cycle multiplier (response at T+1)
//   undefined -> multiplies use the iterative XLEN-cycle loop
//
// Ports:
//   clk_i, rst_n_i         clock, async active-low reset
//   req_valid_i/ready_o    request handshake; funct_i selects op, op1_i/op2_i = rs1/rs2
//   flush_i                abort any in-flight op and drop its response
//   resp_valid_o/ready_i   response handshake; res_o is the result (0 when not valid)

module arith_md #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [2:0]      funct_i,
  input  logic [XLEN-1:0] op1_i,
  input  logic [XLEN-1:0] op2_i,
  input  logic            flush_i,
  output logic            resp_valid_o,
  input  logic            resp_ready_i,
  output logic [XLEN-1:0] res_o
);

  localparam logic [2:0] F_MUL    = 3'd0;
  localparam logic [2:0] F_MULH   = 3'd1;
  localparam logic [2:0] F_MULHSU = 3'd2;
  localparam logic [2:0] F_DIV    = 3'd4;
  localparam logic [2:0] F_REM    = 3'd6;
  localparam int         CW       = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  // Per-operation control, latched at acceptance.
  typedef struct packed {
    logic is_div;   // divide loop instead of multiply loop
    logic sel_hi;   // mul: return high half; div: return remainder
    logic neg_res;  // negate the magnitude result at the end
  } op_t;

  state_t          state;
  op_t             op;
  logic [CW-1:0]   cnt;
  logic [2*XLEN-1:0] p;     // mul: {acc, multiplier}; div: {remainder, quotient}
  logic [XLEN-1:0] opb;     // mul: multiplicand magnitude; div: divisor magnitude

  // ---------------- acceptance-time decode ----------------
  logic            signed1, signed2, op1_neg, op2_neg, div0, ovf;
  logic [XLEN-1:0] a_mag, b_mag, byp_res;

  always_comb begin
    signed1 = (funct_i == F_MULH) || (funct_i == F_MULHSU) ||
              (funct_i == F_DIV)  || (funct_i == F_REM);
    signed2 = (funct_i == F_MULH) || (funct_i == F_DIV) || (funct_i == F_REM);
    op1_neg = signed1 & op1_i[XLEN-1];
    op2_neg = signed2 & op2_i[XLEN-1];
    a_mag   = op1_neg ? -op1_i : op1_i;
    b_mag   = op2_neg ? -op2_i : op2_i;
    div0    = funct_i[2] && (op2_i == '0);
    ovf     = ((funct_i == F_DIV) || (funct_i == F_REM)) &&
              (op1_i == MIN_NEG) && (op2_i == '1);
    // funct_i[1] distinguishes REM/REMU from DIV/DIVU
    if (div0) byp_res = funct_i[1] ? op1_i : '1;
    else      byp_res = funct_i[1] ? '0    : op1_i;
  end

`ifdef ARITH_MD_FAST_MUL_EN
  logic [2*XLEN-1:0] ext1, ext2, fast_prod;
  logic [XLEN-1:0]   fast_res;

  always_comb begin
    ext1      = signed1 ? {{XLEN{op1_i[XLEN-1]}}, op1_i} : {{XLEN{1'b0}}, op1_i};
    ext2      = signed2 ? {{XLEN{op2_i[XLEN-1]}}, op2_i} : {{XLEN{1'b0}}, op2_i};
    fast_prod = ext1 * ext2;
    fast_res  = (funct_i == F_MUL) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
  end
`endif

  // ---------------- one iteration of the loop ----------------
  logic [XLEN:0]     sum, shl, diff;
  logic [2*XLEN-1:0] p_mul, p_div, p_nxt, prod_fix;
  logic [XLEN-1:0]   q, r, fin_res;
  logic              last;

  always_comb begin
    // shift-add: add multiplicand into the high half when the multiplier LSB is set
    sum   = {1'b0, p[2*XLEN-1:XLEN]} + {1'b0, (p[0] ? opb : '0)};
    p_mul = {sum, p[XLEN-1:1]};
    // restoring divide: shift in next dividend bit, subtract when it fits
    shl   = p[2*XLEN-1:XLEN-1];
    diff  = shl - {1'b0, opb};
    if (!diff[XLEN]) p_div = {diff[XLEN-1:0], p[XLEN-2:0], 1'b1};
    else             p_div = {shl[XLEN-1:0],  p[XLEN-2:0], 1'b0};
    p_nxt = op.is_div ? p_div : p_mul;

    prod_fix = op.neg_res ? -p_nxt : p_nxt;
    q        = p_nxt[XLEN-1:0];
    r        = p_nxt[2*XLEN-1:XLEN];
    if (op.is_div) begin
      if (op.sel_hi) fin_res = op.neg_res ? -r : r;
      else           fin_res = op.neg_res ? -q : q;
    end else begin
      fin_res = op.sel_hi ? prod_fix[2*XLEN-1:XLEN] : prod_fix[XLEN-1:0];
    end
    last = (cnt == CW'(XLEN-1));
  end

  // ---------------- control FSM with registered outputs ----------------
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state        <= IDLE;
      req_ready_o  <= 1'b1;
      resp_valid_o <= 1'b0;
      res_o        <= '0;
      cnt          <= '0;
      p            <= '0;
      opb          <= '0;
      op           <= '0;
    end else if (flush_i) begin
      // flush beats a same-cycle request and drops any pending response
      state        <= IDLE;
      req_ready_o  <= 1'b1;
      resp_valid_o <= 1'b0;
      res_o        <= '0;
      cnt          <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid_i) begin
            req_ready_o <= 1'b0;
            if (div0 || ovf) begin
              state        <= DONE;
              resp_valid_o <= 1'b1;
              res_o        <= byp_res;
            end
`ifdef ARITH_MD_FAST_MUL_EN
            else if (!funct_i[2]) begin
              state        <= DONE;
              resp_valid_o <= 1'b1;
              res_o        <= fast_res;
            end
`endif
            else begin
              state      <= BUSY;
              cnt        <= '0;
              op.is_div  <= funct_i[2];
              op.sel_hi  <= funct_i[2] ? funct_i[1] : (funct_i != F_MUL);
              // remainder takes the dividend sign; quotient/product the sign xor
              op.neg_res <= (funct_i[2] && funct_i[1]) ? op1_neg : (op1_neg ^ op2_neg);
              p          <= funct_i[2] ? {{XLEN{1'b0}}, a_mag} : {{XLEN{1'b0}}, b_mag};
              opb        <= funct_i[2] ? b_mag : a_mag;
            end
          end
        end
        BUSY: begin
          p   <= p_nxt;
          cnt <= cnt + CW'(1);
          if (last) begin
            state        <= DONE;
            resp_valid_o <= 1'b1;
            res_o        <= fin_res;
          end
        end
        DONE: begin
          if (resp_ready_i) begin
            state        <= IDLE;
            req_ready_o  <= 1'b1;
            resp_valid_o <= 1'b0;
            res_o        <= '0;
          end
        end
        default: begin
          state        <= IDLE;
          req_ready_o  <= 1'b1;
          resp_valid_o <= 1'b0;
          res_o        <= '0;
        end
      endcase
    end
  end

endmodule
